// File: rtl/fma_result_collector.sv
// fma_result_collector
//   Sits behind stage 5 of the free-running FMA pipeline. A {valid,tag} delay
//   line tracks granted ops so each result is captured in the cycle it appears
//   on res_data. Captured results are classified and queued in a FIFO for a
//   valid/ready consumer. Issue is credit-gated: an op is granted only when a
//   FIFO slot is already reserved for it, so a capture never meets a full FIFO.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   issue_req/tag     upstream op offer and its tag
//   issue_grant       op accepted this cycle (combinational)
//   res_data          stage-5 result {sign, exp[7:0], man[22:0]}
//   out_valid/ready   FIFO head handshake
//   out_data/tag      head result word and tag
//   out_flags         head class {is_nan, is_inf, is_zero}
//   credits           free credits (DEPTH - in flight - level)
//   level             FIFO occupancy
module fma_result_collector #(
  parameter int DEPTH    = 8,
  parameter int TAG_W    = 4,
  parameter int PIPE_LAT = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_req,
  input  logic [TAG_W-1:0]             issue_tag,
  output logic                         issue_grant,
  input  logic [31:0]                  res_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic [TAG_W-1:0]             out_tag,
  output logic [2:0]                   out_flags,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [PIPE_LAT-1:0] dl_vld;
  logic [TAG_W-1:0]    dl_tag [PIPE_LAT];

  logic [31:0]      mem_data  [DEPTH];
  logic [TAG_W-1:0] mem_tag   [DEPTH];
  logic [2:0]       mem_flags [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0] level_n;

  logic          push, pop, head_from_write;
  logic [TAG_W-1:0] cap_tag;
  logic [2:0]    cap_flags;
  logic [7:0]    cap_exp;
  logic [22:0]   cap_man;

  assign issue_grant = issue_req && (credits != '0) && !rst;

  assign push    = dl_vld[PIPE_LAT-1];
  assign cap_tag = dl_tag[PIPE_LAT-1];
  assign pop     = out_valid && out_ready;

  assign cap_exp = res_data[30:23];
  assign cap_man = res_data[22:0];

  always_comb begin
    cap_flags    = 3'b000;
    cap_flags[2] = (cap_exp == 8'hFF) && (cap_man != '0);
    cap_flags[1] = (cap_exp == 8'hFF) && (cap_man == '0);
    cap_flags[0] = (cap_exp == 8'h00) && (cap_man == '0);
  end

  always_comb begin
    level_n  = level + CW'(push) - CW'(pop);
    rd_ptr_n = rd_ptr + AW'(pop);
    // The next head is the word being written when nothing else remains
    // queued after this cycle's pop; storage is not yet updated for it.
    head_from_write = (level == CW'(pop));
  end

  // Tags carry no reset: they are only observed when the matching valid is set.
  always_ff @(posedge clk) begin
    dl_tag[0] <= issue_tag;
    for (int i = 1; i < PIPE_LAT; i++) dl_tag[i] <= dl_tag[i-1];
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_data[wr_ptr]  <= res_data;
      mem_tag[wr_ptr]   <= cap_tag;
      mem_flags[wr_ptr] <= cap_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      credits   <= CW'(DEPTH);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else begin
      dl_vld[0] <= issue_grant;
      for (int i = 1; i < PIPE_LAT; i++) dl_vld[i] <= dl_vld[i-1];

      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_n;
      level   <= level_n;
      credits <= credits - CW'(issue_grant) + CW'(pop);

      out_valid <= (level_n != '0);
      // Head registers hold their last contents while the FIFO is empty.
      if (level_n != '0) begin
        if (head_from_write) begin
          out_data  <= res_data;
          out_tag   <= cap_tag;
          out_flags <= cap_flags;
        end else begin
          out_data  <= mem_data[rd_ptr_n];
          out_tag   <= mem_tag[rd_ptr_n];
          out_flags <= mem_flags[rd_ptr_n];
        end
      end
    end
  end

  // Credits reserve a slot for every in-flight op, so this cannot happen.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (level == CW'(DEPTH))));

endmodule

// File: tb/tb_fma_result_collector.sv
module tb_fma_result_collector;

  localparam int DEPTH    = 8;
  localparam int TAG_W    = 4;
  localparam int PIPE_LAT = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_req;
  logic [TAG_W-1:0]  issue_tag;
  logic              issue_grant;
  logic [31:0]       res_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [2:0]        out_flags;
  logic [3:0]        credits;
  logic [3:0]        level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fma_result_collector #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_req   (issue_req),
    .issue_tag   (issue_tag),
    .issue_grant (issue_grant),
    .res_data    (res_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_flags   (out_flags),
    .credits     (credits),
    .level       (level)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well before next edge).
  task automatic look();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_req = 1'b0;
    issue_tag = '0;
    res_data  = '0;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [31:0] fvals [4];
  logic [2:0]  fexp  [4];

  initial begin
    fvals[0] = 32'h7F800000; fexp[0] = 3'b010;
    fvals[1] = 32'h7FC00000; fexp[1] = 3'b100;
    fvals[2] = 32'h80000000; fexp[2] = 3'b001;
    fvals[3] = 32'h00000001; fexp[3] = 3'b000;

    // 1: reset and a single op
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      issue_req = (c == 0);
      issue_tag = 4'd3;
      res_data  = (c == 5) ? 32'h40400000 : 32'h0;
      out_ready = 1'b1;
      look();
      if (c == 0) begin
        chk("t1_rst_credits", credits, 8);
        chk("t1_rst_level", level, 0);
        chk("t1_rst_valid", out_valid, 0);
        chk("t1_grant", issue_grant, 1);
      end
      if (c == 1) chk("t1_credits7", credits, 7);
      if (c == 5) chk("t1_no_early_valid", out_valid, 0);
      if (c == 6) begin
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'h40400000);
        chk("t1_tag", out_tag, 3);
        chk("t1_flags", out_flags, 3'b000);
      end
      if (c == 7) begin
        chk("t1_credits_back", credits, 8);
        chk("t1_level0", level, 0);
      end
      cyc();
    end

    // 2: backpressure until credits run out, then drain in order
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      issue_req = (c < 12);
      issue_tag = 4'(c);
      out_ready = (c >= 13);
      res_data  = 32'(c);
      look();
      if (c < 12) chk("t2_grant", issue_grant, (c < 8) ? 1 : 0);
      if (c >= 8 && c < 12) chk("t2_credits0", credits, 0);
      if (c == 10) begin
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_hold_tag", out_tag, 0);
      end
      if (c == 13) chk("t2_level8", level, 8);
      if (c >= 13 && c <= 20) begin
        chk("t2_drain_valid", out_valid, 1);
        chk("t2_drain_tag", out_tag, c - 13);
      end
      if (c == 21) begin
        chk("t2_empty", out_valid, 0);
        chk("t2_credits8", credits, 8);
      end
      cyc();
    end

    // 3: grant, push and pop in one cycle with credits=4
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      issue_req = (c < 4) || (c == 8);
      issue_tag = (c == 8) ? 4'd9 : 4'(c);
      out_ready = (c >= 8);
      res_data  = 32'h3F800000;
      look();
      if (c == 8) begin
        chk("t3_pre_credits", credits, 4);
        chk("t3_pre_level", level, 3);
        chk("t3_grant", issue_grant, 1);
        chk("t3_head_tag", out_tag, 0);
      end
      if (c == 9) begin
        chk("t3_post_credits", credits, 4);
        chk("t3_post_level", level, 3);
        chk("t3_next_tag", out_tag, 1);
      end
      if (c == 14) begin
        chk("t3_late_valid", out_valid, 1);
        chk("t3_late_tag", out_tag, 9);
      end
      if (c == 15) begin
        chk("t3_end_credits", credits, 8);
        chk("t3_end_level", level, 0);
      end
      cyc();
    end

    // 4: class flags
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      issue_req = (c < 4);
      issue_tag = 4'(c);
      out_ready = 1'b1;
      res_data  = (c >= 5 && c < 9) ? fvals[c-5] : 32'h0;
      look();
      if (c >= 6 && c < 10) begin
        chk("t4_valid", out_valid, 1);
        chk("t4_tag", out_tag, c - 6);
        chk("t4_data", out_data, fvals[c-6]);
        chk("t4_flags", out_flags, fexp[c-6]);
      end
      cyc();
    end

    // 5: reset while ops are in flight
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      issue_req = (c < 4);
      issue_tag = 4'(c);
      rst       = (c == 3);
      out_ready = 1'b1;
      res_data  = 32'h3F800000;
      look();
      if (c < 3) chk("t5_grant", issue_grant, 1);
      if (c == 3) chk("t5_grant_in_rst", issue_grant, 0);
      if (c >= 4) chk("t5_no_valid", out_valid, 0);
      if (c == 4) chk("t5_credits8", credits, 8);
      if (c == 12) chk("t5_level0", level, 0);
      cyc();
    end
    rst = 1'b0;

    // 6: 20 back-to-back ops through the wrapping FIFO
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      issue_req = (c < 20);
      issue_tag = 4'(c % 16);
      out_ready = 1'b1;
      res_data  = 32'(c);
      look();
      if (c < 20) chk("t6_grant", issue_grant, 1);
      if (c >= 6 && c <= 25) begin
        chk("t6_valid", out_valid, 1);
        chk("t6_tag", out_tag, (c - 6) % 16);
        chk("t6_data", out_data, c - 1);
      end
      chk("t6_level_le1", (level <= 4'd1), 1);
      if (c == 26) chk("t6_empty", out_valid, 0);
      if (c == 27) chk("t6_credits8", credits, 8);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
